// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mux: PS/2 scancodes, key latch slots,
// joystick bit layout helpers and the SOCD mode encoding.
package arcade_input_pkg;

   // PS/2 set-2 scancodes recognised by the keyboard path
   localparam logic [7:0] SC_START1  = 8'h16;
   localparam logic [7:0] SC_START2  = 8'h1E;
   localparam logic [7:0] SC_COIN1   = 8'h2E;
   localparam logic [7:0] SC_COIN2   = 8'h36;
   localparam logic [7:0] SC_SERVICE = 8'h46;
   localparam logic [7:0] SC_UP      = 8'h75;
   localparam logic [7:0] SC_DOWN    = 8'h72;
   localparam logic [7:0] SC_LEFT    = 8'h6B;
   localparam logic [7:0] SC_RIGHT   = 8'h74;
   localparam logic [7:0] SC_BTN0    = 8'h14;
   localparam logic [7:0] SC_BTN1    = 8'h11;
   localparam logic [7:0] SC_BTN2    = 8'h29;

   // Slot of each key inside the key-state latch vector
   localparam int K_START1  = 0;
   localparam int K_START2  = 1;
   localparam int K_COIN1   = 2;
   localparam int K_COIN2   = 3;
   localparam int K_SERVICE = 4;
   localparam int K_UP      = 5;
   localparam int K_DOWN    = 6;
   localparam int K_LEFT    = 7;
   localparam int K_RIGHT   = 8;
   localparam int K_BTN0    = 9;
   localparam int K_BTN1    = 10;
   localparam int K_BTN2    = 11;
   localparam int NUM_KEYS  = 12;

   // Fixed part of the per-player 16-bit joystick word
   localparam int JOY_R    = 0;
   localparam int JOY_L    = 1;
   localparam int JOY_D    = 2;
   localparam int JOY_U    = 3;
   localparam int JOY_BTN0 = 4;

   // HPS download indexes
   localparam logic [7:0] IDX_HEADER = 8'd1;
   localparam logic [7:0] IDX_DIP    = 8'd254;

   typedef enum logic [1:0] {
      SOCD_PASS      = 2'd0,
      SOCD_NEUTRAL   = 2'd1,
      SOCD_LAST_WINS = 2'd2,
      SOCD_RSVD      = 2'd3
   } socd_mode_e;

   // Joystick bit positions that move with the button count
   function automatic int start_idx(input int nb);
      return nb + 4;
   endfunction

   function automatic int coin_idx(input int nb);
      return nb + 5;
   endfunction

   function automatic int pause_idx(input int nb);
      return nb + 7;
   endfunction

endpackage

// File: rtl/coin_stretch.sv
// Stretches a coin request into a pulse of at least COIN_CYC clocks.
// The pulse lasts max(request length, COIN_CYC); new rising edges while the
// pulse is active are ignored. After reset the request must be seen low
// before a rising edge can start a pulse, so a held request never fires on
// reset release.
module coin_stretch
   import arcade_input_pkg::*;
#(
   parameter int COIN_CYC = 4915200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic coin_n
);

   localparam int              CNT_W   = $clog2(COIN_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COIN_CYC);

   logic             req_prev_q, req_prev_d;
   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Edge detect, start the pulse, count up to COIN_CYC and hold while requested
   always_comb begin
      req_prev_d = req;
      active_d   = active_q;
      cnt_d      = cnt_q;
      if (!active_q) begin
         if (req && !req_prev_q) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(1);
         end
      end else begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         if ((cnt_q == CNT_MAX) && !req) begin
            active_d = 1'b0;
            cnt_d    = '0;
         end
      end
   end

   // Pulse state; previous-request flop resets high to block a release-time edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_q <= 1'b1;
         active_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         req_prev_q <= req_prev_d;
         active_q   <= active_d;
         cnt_q      <= cnt_d;
      end
   end

   assign coin_n = ~active_q;

endmodule

// File: rtl/arcade_input_mux.sv
// Merges PS/2 keyboard and per-player joysticks into active-low arcade
// inputs, with SOCD cleaning, coin pulse stretching, DIP switch storage
// loaded over the HPS download bus and ROM header flag capture.
module arcade_input_mux
   import arcade_input_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_BUTTONS = 3,
   parameter int DIP_BANKS   = 3,
   parameter int COIN_CYC    = 4915200
) (
   input  logic                             clk_49m,
   input  logic                             reset,
   input  logic [10:0]                      ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]        joystick,
   input  logic                             ioctl_wr,
   input  logic [7:0]                       ioctl_index,
   input  logic [24:0]                      ioctl_addr,
   input  logic [7:0]                       ioctl_dout,
   input  logic [1:0]                       socd_mode,
   output logic [4*NUM_PLAYERS-1:0]         dir_n,
   output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_n,
   output logic [NUM_PLAYERS-1:0]           start_n,
   output logic [NUM_PLAYERS-1:0]           coin_n,
   output logic                             service_n,
   output logic                             pause_req,
   output logic [8*DIP_BANKS-1:0]           dipsw,
   output logic [1:0]                       is_bootleg,
   output logic                             is_japan
);

   socd_mode_e mode;
   assign mode = socd_mode_e'(socd_mode);

   // ps2_key[8] (extended prefix) and the spare joystick bits are not decoded
   logic unused_bits;
   assign unused_bits = ^{ps2_key[8], joystick};

   // ---------------------------------------------------------------------
   // Keyboard latches
   // ---------------------------------------------------------------------
   logic                key_tog_q, key_tog_d;
   logic [NUM_KEYS-1:0] key_q, key_d;

   // Update the key latch addressed by the scancode whenever the strobe toggles
   always_comb begin
      key_tog_d = ps2_key[10];
      key_d     = key_q;
      if (ps2_key[10] != key_tog_q) begin
         case (ps2_key[7:0])
            SC_START1:  key_d[K_START1]  = ps2_key[9];
            SC_START2:  key_d[K_START2]  = ps2_key[9];
            SC_COIN1:   key_d[K_COIN1]   = ps2_key[9];
            SC_COIN2:   key_d[K_COIN2]   = ps2_key[9];
            SC_SERVICE: key_d[K_SERVICE] = ps2_key[9];
            SC_UP:      key_d[K_UP]      = ps2_key[9];
            SC_DOWN:    key_d[K_DOWN]    = ps2_key[9];
            SC_LEFT:    key_d[K_LEFT]    = ps2_key[9];
            SC_RIGHT:   key_d[K_RIGHT]   = ps2_key[9];
            SC_BTN0:    key_d[K_BTN0]    = ps2_key[9];
            SC_BTN1:    key_d[K_BTN1]    = ps2_key[9];
            SC_BTN2:    key_d[K_BTN2]    = ps2_key[9];
            default:    ;
         endcase
      end
   end

   // Keyboard contribution per player: player 0 gets everything, player 1
   // only start2/coin2, the rest get nothing
   logic [NUM_PLAYERS-1:0][3:0]             key_dir;
   logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] key_btn;
   logic [NUM_PLAYERS-1:0]                  key_start;
   logic [NUM_PLAYERS-1:0]                  key_coin;

   // Route key latches to the player inputs they belong to
   always_comb begin
      key_dir      = '0;
      key_btn      = '0;
      key_start    = '0;
      key_coin     = '0;
      key_dir[0]   = {key_q[K_UP], key_q[K_DOWN], key_q[K_LEFT], key_q[K_RIGHT]};
      key_btn[0]   = NUM_BUTTONS'(key_q[K_BTN2:K_BTN0]);
      key_start[0] = key_q[K_START1];
      key_start[1] = key_q[K_START2];
      key_coin[0]  = key_q[K_COIN1];
      key_coin[1]  = key_q[K_COIN2];
   end

   // ---------------------------------------------------------------------
   // Per-player path
   // ---------------------------------------------------------------------
   logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] all_btn;
   logic [NUM_PLAYERS-1:0]                  joy_pause;
   logic                                    japan_q, japan_d;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
      localparam int BASE      = 16 * g;
      localparam int START_BIT = BASE + start_idx(NUM_BUTTONS);
      localparam int COIN_BIT  = BASE + coin_idx(NUM_BUTTONS);
      localparam int PAUSE_BIT = BASE + pause_idx(NUM_BUTTONS);

      // raw_dir bit order follows the joystick word: [3]U [2]D [1]L [0]R
      logic [3:0]             raw_dir;
      logic [NUM_BUTTONS-1:0] raw_btn;
      logic                   raw_start;
      logic                   raw_coin;

      assign raw_dir      = joystick[BASE +: 4] | key_dir[g];
      assign raw_btn      = joystick[BASE + JOY_BTN0 +: NUM_BUTTONS] | key_btn[g];
      assign raw_start    = joystick[START_BIT] | key_start[g];
      assign raw_coin     = joystick[COIN_BIT] | key_coin[g];
      assign joy_pause[g] = joystick[PAUSE_BIT];
      assign all_btn[g]   = raw_btn;

      // SOCD history: previous raw directions and per-axis owner of the
      // last rising edge (win[1]: 1 = D owns vertical, win[0]: 1 = R owns horizontal)
      logic [3:0] prev_q, prev_d;
      logic [1:0] win_q, win_d;
      logic [3:0] soc_dir;

      // Track the later rising edge per axis and resolve opposing directions
      always_comb begin
         prev_d = raw_dir;
         win_d  = win_q;
         if (raw_dir[JOY_U] && !prev_q[JOY_U]) begin
            win_d[1] = 1'b0;
         end else if (raw_dir[JOY_D] && !prev_q[JOY_D]) begin
            win_d[1] = 1'b1;
         end
         if (raw_dir[JOY_L] && !prev_q[JOY_L]) begin
            win_d[0] = 1'b0;
         end else if (raw_dir[JOY_R] && !prev_q[JOY_R]) begin
            win_d[0] = 1'b1;
         end

         soc_dir = raw_dir;
         if (mode == SOCD_NEUTRAL) begin
            if (raw_dir[JOY_U] && raw_dir[JOY_D]) soc_dir[3:2] = 2'b00;
            if (raw_dir[JOY_L] && raw_dir[JOY_R]) soc_dir[1:0] = 2'b00;
         end else if (mode == SOCD_LAST_WINS) begin
            if (raw_dir[JOY_U] && raw_dir[JOY_D]) soc_dir[3:2] = win_d[1] ? 2'b01 : 2'b10;
            if (raw_dir[JOY_L] && raw_dir[JOY_R]) soc_dir[1:0] = win_d[0] ? 2'b01 : 2'b10;
         end
      end

      // Japanese sets swap the last button between players 0 and 1
      logic [NUM_BUTTONS-1:0] btn_fin;
      if (g < 2) begin : g_swap
         // Take the partner player's last button when the Japan flag is set
         always_comb begin
            btn_fin = raw_btn;
            if (japan_q) begin
               btn_fin[NUM_BUTTONS-1] = all_btn[1-g][NUM_BUTTONS-1];
            end
         end
      end else begin : g_noswap
         assign btn_fin = raw_btn;
      end

      logic [3:0]             dir_n_q, dir_n_d;
      logic [NUM_BUTTONS-1:0] btn_n_q, btn_n_d;
      logic                   start_n_q, start_n_d;

      // Active-low output encoding, directions reordered to {D,U,R,L}
      always_comb begin
         dir_n_d   = ~{soc_dir[JOY_D], soc_dir[JOY_U], soc_dir[JOY_R], soc_dir[JOY_L]};
         btn_n_d   = ~btn_fin;
         start_n_d = ~raw_start;
      end

      // Per-player SOCD history and registered outputs
      always_ff @(posedge clk_49m or negedge reset) begin
         if (!reset) begin
            prev_q    <= '0;
            win_q     <= '0;
            dir_n_q   <= '1;
            btn_n_q   <= '1;
            start_n_q <= 1'b1;
         end else begin
            prev_q    <= prev_d;
            win_q     <= win_d;
            dir_n_q   <= dir_n_d;
            btn_n_q   <= btn_n_d;
            start_n_q <= start_n_d;
         end
      end

      assign dir_n[4*g +: 4]                     = dir_n_q;
      assign btn_n[NUM_BUTTONS*g +: NUM_BUTTONS] = btn_n_q;
      assign start_n[g]                          = start_n_q;

      coin_stretch #(
         .COIN_CYC (COIN_CYC)
      ) u_coin (
         .clk    (clk_49m),
         .rst_n  (reset),
         .req    (raw_coin),
         .coin_n (coin_n[g])
      );
   end

   // ---------------------------------------------------------------------
   // DIP switch bytes, dropped when the address is past the last bank
   // ---------------------------------------------------------------------
   logic dip_wr;
   assign dip_wr = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr < 25'(DIP_BANKS));

   for (genvar k = 0; k < DIP_BANKS; k++) begin : g_dip
      logic [7:0] byte_q, byte_d;

      // Load this bank when the download bus addresses it
      always_comb begin
         byte_d = byte_q;
         if (dip_wr && (ioctl_addr == 25'(k))) begin
            byte_d = ioctl_dout;
         end
      end

      // Stored DIP byte
      always_ff @(posedge clk_49m or negedge reset) begin
         if (!reset) begin
            byte_q <= '0;
         end else begin
            byte_q <= byte_d;
         end
      end

      assign dipsw[8*k +: 8] = ~byte_q;
   end

   // ---------------------------------------------------------------------
   // Header flags, service and pause
   // ---------------------------------------------------------------------
   logic [1:0] bootleg_q, bootleg_d;
   logic       service_n_q, service_n_d;
   logic       pause_q, pause_d;

   // Capture header byte 0 on a write strobe; merge service and pause
   always_comb begin
      bootleg_d   = bootleg_q;
      japan_d     = japan_q;
      if (ioctl_wr && (ioctl_index == IDX_HEADER) && (ioctl_addr == '0)) begin
         bootleg_d = ioctl_dout[1:0];
         japan_d   = ioctl_dout[4];
      end
      service_n_d = ~key_q[K_SERVICE];
      pause_d     = |joy_pause;
   end

   // Shared registers: key latches, header flags, service and pause outputs
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         key_tog_q   <= 1'b0;
         key_q       <= '0;
         bootleg_q   <= '0;
         japan_q     <= 1'b0;
         service_n_q <= 1'b1;
         pause_q     <= 1'b0;
      end else begin
         key_tog_q   <= key_tog_d;
         key_q       <= key_d;
         bootleg_q   <= bootleg_d;
         japan_q     <= japan_d;
         service_n_q <= service_n_d;
         pause_q     <= pause_d;
      end
   end

   assign is_bootleg = bootleg_q;
   assign is_japan   = japan_q;
   assign service_n  = service_n_q;
   assign pause_req  = pause_q;

endmodule
